// File: rtl/rv32_load_store_unit.sv
// RV32 load/store unit: 4-state FSM between the pipeline and the data port.
// Optional statistics counters are enabled with `define RV32_LSU_STATS_EN.
package rv32_types;
    typedef enum logic [3:0] {
        MEM_NOP,
        MEM_LB,
        MEM_LBU,
        MEM_LH,
        MEM_LHU,
        MEM_LW,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        mem_op_t     op;
    } memory_request_t;
endpackage

module rv32_load_store_unit
    import rv32_types::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  mem_op_t         req_op,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [4:0]      req_rd,
    output memory_request_t mem_request,
    input  logic            mem_ready,
    input  logic [31:0]     mem_data,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic [4:0]      resp_rd,
    output logic [1:0]      resp_fault,
    output logic [31:0]     load_count,
    output logic [31:0]     store_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DATA,
        S_RESP
    } state_t;

    state_t      r_state;
    mem_op_t     r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic [7:0]  r_wait;
    logic [31:0] r_resp_rdata;
    logic [4:0]  r_resp_rd;
    logic [1:0]  r_resp_fault;

    logic        w_misaligned;
    logic        w_is_load;
    logic        w_busy;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    always_comb begin
        w_misaligned = 1'b0;
        case (req_op)
            MEM_LH, MEM_LHU, MEM_SH: w_misaligned = req_addr[0];
            MEM_LW, MEM_SW:          w_misaligned = |req_addr[1:0];
            default:                 w_misaligned = 1'b0;
        endcase
    end

    assign w_is_load = r_op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    assign w_busy    = (r_state == S_ISSUE) || (r_state == S_WAIT_DATA);

    // The op is only qualified by mem_ready so a store lands exactly once.
    assign mem_request = '{
        addr: w_busy ? r_addr : 32'd0,
        data: r_wdata,
        op:   ((r_state == S_ISSUE) && mem_ready) ? r_op : MEM_NOP
    };

    always_comb begin
        w_byte = mem_data[{r_addr[1:0], 3'b000} +: 8];
        w_half = mem_data[{r_addr[1], 4'b0000} +: 16];
        case (r_op)
            MEM_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: w_load = {24'd0, w_byte};
            MEM_LH:  w_load = {{16{w_half[15]}}, w_half};
            MEM_LHU: w_load = {16'd0, w_half};
            default: w_load = mem_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_op         <= MEM_NOP;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_rd         <= 5'd0;
            r_wait       <= 8'd0;
            r_resp_rdata <= 32'd0;
            r_resp_rd    <= 5'd0;
            r_resp_fault <= 2'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid && req_op != MEM_NOP) begin
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rd    <= req_rd;
                        if (w_misaligned) begin
                            r_state      <= S_RESP;
                            r_resp_fault <= 2'd1;
                            r_resp_rdata <= 32'd0;
                            r_resp_rd    <= req_rd;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        r_wait <= 8'd0;
                        if (w_is_load) begin
                            r_state <= S_WAIT_DATA;
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_fault <= 2'd0;
                            r_resp_rdata <= 32'd0;
                            r_resp_rd    <= r_rd;
                        end
                    end else if (r_wait == 8'(MAX_WAIT - 1)) begin
                        r_wait       <= 8'd0;
                        r_state      <= S_RESP;
                        r_resp_fault <= 2'd2;
                        r_resp_rdata <= 32'd0;
                        r_resp_rd    <= r_rd;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_WAIT_DATA: begin
                    r_state      <= S_RESP;
                    r_resp_fault <= 2'd0;
                    r_resp_rdata <= w_load;
                    r_resp_rd    <= r_rd;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_rd    = r_resp_rd;
    assign resp_fault = r_resp_fault;

`ifdef RV32_LSU_STATS_EN
    logic [31:0] r_load_count;
    logic [31:0] r_store_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_load_count  <= 32'd0;
            r_store_count <= 32'd0;
        end else if (r_state == S_RESP && r_resp_fault == 2'd0) begin
            if (w_is_load) begin
                r_load_count <= r_load_count + 32'd1;
            end else begin
                r_store_count <= r_store_count + 32'd1;
            end
        end
    end

    assign load_count  = r_load_count;
    assign store_count = r_store_count;
`else
    assign load_count  = 32'd0;
    assign store_count = 32'd0;
`endif

endmodule
